wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Shares the register file's single write port between two writeback sources: the single-cycle ALU/load path (port 0) and a multi-cycle execution unit (port 1, e.g. mul/div). Arbitration is fixed-priority to port 0 with an anti-starvation counter for port 1. Grants are registered into a write stage that drives the register file write port. An optional scoreboard tracks destinations with long-latency writes in flight, so issue logic can stall on read-after-write hazards.

## Interface
- `D_WIDTH`, 32, data width
- `ADDRESS_WIDTH`, 5, register address width
- `WAIT_MAX`, 4, consecutive cycles port 1 may wait before it takes priority (≥1)

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `v0` / `addr0` / `data0` in 1 / `ADDRESS_WIDTH` / `D_WIDTH`: port 0 request.
- `rdy0` out 1: port 0 grant.
- `v1` / `addr1` / `data1` in 1 / `ADDRESS_WIDTH` / `D_WIDTH`: port 1 request.
- `rdy1` out 1: port 1 grant.
- `wr_en` / `a3` / `din` out 1 / `ADDRESS_WIDTH` / `D_WIDTH`: register file write port.
- `set_en` / `set_addr` in 1 / `ADDRESS_WIDTH`: marks a destination pending at issue of a long-latency op.
- `rs1` / `rs2` in `ADDRESS_WIDTH`: issue-stage source addresses.
- `hz1` / `hz2` out 1: source register is pending.
- `busy` out `2**ADDRESS_WIDTH`: pending bitmask.

## Operation
- **Handshake:** transfer occurs when `vN && rdyN` at a posedge. Once `vN` is asserted, the requester holds it and its addr/data stable until the transfer. `vN` must not depend on `rdyN`.
- **Grant:**
  - `rdy0 = v0 && !(v1 && starve)`.
  - `rdy1 = v1 && (!v0 || starve)`.
  - At most one grant per cycle. `starve = (wait_cnt >= WAIT_MAX)`.
- **wait_cnt:**
  - Increments (saturating at `WAIT_MAX`) each cycle `v1 && !rdy1`.
  - Clears on a port 1 transfer.
  - Holds when `v1 = 0`.
- **Write stage:** on a transfer, register `{addr, data, src}`. Output `wr_en = 1` for exactly one cycle with `a3`/`din` equal to the granted request. With no transfer, `wr_en = 0` and `a3`/`din` hold their last values.
- **x0:** a transfer with addr 0 completes the handshake normally, but `wr_en` stays 0 for that cycle.
- **Scoreboard:**
  - Set: `set_en` with nonzero `set_addr` sets `busy[set_addr]`. `set_addr = 0` is ignored.
  - Clear: `busy[a3]` clears on the posedge that ends a cycle where `wr_en = 1` and `src = 1`.
  - Simultaneous set and clear of the same address: set wins.
  - Port 0 writes never clear `busy`.
- **Hazard outputs:** `hz1 = busy[rs1]` and `hz2 = busy[rs2]`, combinational from state. `busy[0]` is always 0.
- **Reset:**
  - All state is cleared: `wr_en = 0`, `a3 = 0`, `din = 0`, `src = 0`, `wait_cnt = 0`, `busy = 0`.
  - `rdy0`/`rdy1` follow `v0`/`v1` combinationally, including while `rst` is high. Any transfer during reset is discarded and is not written.

## Timing
- **Grant latency:** `rdyN` is combinational in the same cycle as `vN`.
- **Write latency:** transfer at posedge N gives `wr_en`/`a3`/`din` valid during cycle N+1. The register file captures the data at the negedge inside N+1, so it is readable in the second half of N+1.
- **Scoreboard clear:** the busy bit drops at posedge end of N+1 and is visible from cycle N+2. An issue stalled on `hz` therefore never reads stale data.
- **Throughput:** one write per cycle sustained.
- **Worst-case port 1 wait:** `WAIT_MAX` cycles under continuous port 0 traffic.

## Configuration
- `WB_SCOREBOARD_EN`
  - Defined: scoreboard, `busy`, `hz1` and `hz2` are implemented as above.
  - Undefined: no scoreboard state. `busy`, `hz1` and `hz2` are tied to 0, and `set_en`/`set_addr` are ignored. Arbitration and the write stage are unchanged.

## Structure
- **Package `wb_arb_pkg`:**
  - Default width constants.
  - `wb_req_t` struct (`addr`, `data`).
  - `wb_src_e` enum (`SRC_P0`, `SRC_P1`).
- **Sub-module `wb_scoreboard`:** pending bitmask with set/clear ports and two hazard read ports, instantiated only under `WB_SCOREBOARD_EN`.
- The arbiter, counter and write stage stay in `wb_arbiter`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `v0 = 1`, `addr0 = 5`. Expect `wr_en = 0`, `a3 = 0`, `din = 0` and `busy = 0` through reset. x5 is not written.
- **Contention:** `v0 = v1 = 1` continuously (`addr0 = 3`, `addr1 = 7`). Expect `rdy0` for 4 cycles, then `rdy1` in cycle 5, then port 0 resumes. `wait_cnt` returns to 0.
- **Single write:** port 1 alone with `addr1 = 9`, `data1 = 0xDEADBEEF`. Expect `rdy1` the same cycle, then `wr_en = 1`, `a3 = 9`, `din = 0xDEADBEEF` for exactly one cycle on the next cycle.
- **x0:** port 0 with `addr0 = 0`, `data0 = 0x1234`. Expect `rdy0 = 1` and `wr_en = 0` the next cycle.
- **Scoreboard lifecycle:** `set_en` with `set_addr = 12`, `rs1 = 12`. Expect `hz1 = 1` from the next cycle. Then a port 1 write to 12 is granted at edge N; expect `hz1 = 1` through N+1 and `hz1 = 0` at N+2. A port 0 write to 12 leaves `hz1 = 1`.
- **Set/clear collision:** `set_en` to 12 in the same cycle as port 1 writeback to 12. Expect `busy[12]` to stay 1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and default geometry for the writeback arbiter slice.
//   WB_D_WIDTH        default writeback data width
//   WB_ADDRESS_WIDTH  default register address width
//   WB_WAIT_MAX       default anti-starvation limit for port 1
//   wb_req_t          one writeback request at default geometry (addr, data)
//   wb_src_e          which port produced the write held in the write stage
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int unsigned WB_D_WIDTH       = 32;
    localparam int unsigned WB_ADDRESS_WIDTH = 5;
    localparam int unsigned WB_WAIT_MAX      = 4;

    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] addr;
        logic [WB_D_WIDTH-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        SRC_P0 = 1'b0,
        SRC_P1 = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Pending-destination bitmask for long-latency writes, with one set port,
// one clear port and two combinational hazard read ports.
//   clk_i, rst_i         clock, synchronous active-high reset
//   setEn_i, setAddr_i   mark a destination pending (address 0 ignored)
//   clrEn_i, clrAddr_i   retire a pending destination
//   rs1_i, rs2_i         source addresses to look up
//   hz1_o, hz2_o         source is pending
//   busy_o               full pending bitmask
// ---------------------------------------------------------------------------
module wb_scoreboard #(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        setEn_i,
    input  logic [ADDRESS_WIDTH-1:0]    setAddr_i,
    input  logic                        clrEn_i,
    input  logic [ADDRESS_WIDTH-1:0]    clrAddr_i,
    input  logic [ADDRESS_WIDTH-1:0]    rs1_i,
    input  logic [ADDRESS_WIDTH-1:0]    rs2_i,
    output logic                        hz1_o,
    output logic                        hz2_o,
    output logic [2**ADDRESS_WIDTH-1:0] busy_o
);

    logic [2**ADDRESS_WIDTH-1:0] busy_q;
    logic [2**ADDRESS_WIDTH-1:0] busy_d;

    // Clear is applied before set so that a same-address collision leaves
    // the bit set: the new long-latency op owns the destination now.
    // Bit 0 is forced low because x0 is never a real destination.
    always_comb begin
        busy_d = busy_q;
        if (clrEn_i) begin
            busy_d[clrAddr_i] = 1'b0;
        end
        if (setEn_i && (setAddr_i != '0)) begin
            busy_d[setAddr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Pending mask register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hz1_o  = busy_q[rs1_i];
    assign hz2_o  = busy_q[rs2_i];
    assign busy_o = busy_q;

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Shares the register-file write port between the single-cycle ALU/load path
// (port 0, fixed priority) and a multi-cycle unit (port 1, protected by an
// anti-starvation counter). The granted request is registered into a write
// stage that drives the register file for one cycle.
// Optional feature macro: WB_SCOREBOARD_EN (pending-destination scoreboard).
//   clk, rst                 clock, synchronous active-high reset
//   v0/addr0/data0, rdy0     port 0 request and grant
//   v1/addr1/data1, rdy1     port 1 request and grant
//   wr_en/a3/din             register file write port
//   set_en/set_addr          mark a destination pending at long-latency issue
//   rs1/rs2, hz1/hz2         issue-stage hazard lookup
//   busy                     pending bitmask
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int D_WIDTH       = WB_D_WIDTH,
    parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int WAIT_MAX      = WB_WAIT_MAX
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        v0,
    input  logic [ADDRESS_WIDTH-1:0]    addr0,
    input  logic [D_WIDTH-1:0]          data0,
    output logic                        rdy0,
    input  logic                        v1,
    input  logic [ADDRESS_WIDTH-1:0]    addr1,
    input  logic [D_WIDTH-1:0]          data1,
    output logic                        rdy1,
    output logic                        wr_en,
    output logic [ADDRESS_WIDTH-1:0]    a3,
    output logic [D_WIDTH-1:0]          din,
    input  logic                        set_en,
    input  logic [ADDRESS_WIDTH-1:0]    set_addr,
    input  logic [ADDRESS_WIDTH-1:0]    rs1,
    input  logic [ADDRESS_WIDTH-1:0]    rs2,
    output logic                        hz1,
    output logic                        hz2,
    output logic [2**ADDRESS_WIDTH-1:0] busy
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [D_WIDTH-1:0]       data;
    } req_t;

    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    req_t             wrReq_q, wrReq_d;
    wb_src_e          src_q, src_d;
    logic             wrEn_q, wrEn_d;
    logic             starve;

    // Port 0 wins unless port 1 has waited long enough; grants depend only
    // on requests and counter state, so they are live even during reset.
    assign starve = (waitCnt_q >= WAIT_LIMIT);
    assign rdy0   = v0 && !(v1 && starve);
    assign rdy1   = v1 && (!v0 || starve);

    // Count consecutive losing cycles of port 1; a port 1 transfer restarts
    // the count and an idle port 1 leaves it untouched.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (rdy1) begin
            waitCnt_d = '0;
        end else if (v1 && (waitCnt_q != WAIT_LIMIT)) begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
        end
    end

    // Capture whichever request was granted. Writes to x0 still complete the
    // handshake but never raise wr_en; address/data hold when idle.
    always_comb begin
        wrReq_d = wrReq_q;
        src_d   = src_q;
        wrEn_d  = 1'b0;
        if (rdy0) begin
            wrReq_d = '{addr: addr0, data: data0};
            src_d   = SRC_P0;
            wrEn_d  = (addr0 != '0);
        end else if (rdy1) begin
            wrReq_d = '{addr: addr1, data: data1};
            src_d   = SRC_P1;
            wrEn_d  = (addr1 != '0);
        end
    end

    // Counter and write stage registers; reset discards any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt_q <= '0;
            wrReq_q   <= '0;
            src_q     <= SRC_P0;
            wrEn_q    <= 1'b0;
        end else begin
            waitCnt_q <= waitCnt_d;
            wrReq_q   <= wrReq_d;
            src_q     <= src_d;
            wrEn_q    <= wrEn_d;
        end
    end

    assign wr_en = wrEn_q;
    assign a3    = wrReq_q.addr;
    assign din   = wrReq_q.data;

`ifdef WB_SCOREBOARD_EN
    // Only port 1 writes retire pending destinations.
    wb_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk_i     (clk),
        .rst_i     (rst),
        .setEn_i   (set_en),
        .setAddr_i (set_addr),
        .clrEn_i   (wrEn_q && (src_q == SRC_P1)),
        .clrAddr_i (wrReq_q.addr),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .hz1_o     (hz1),
        .hz2_o     (hz2),
        .busy_o    (busy)
    );
`else
    // Without the scoreboard nothing is ever pending; the lookup and set
    // inputs are deliberately left with no effect.
    logic unusedScoreboardInputs;
    assign unusedScoreboardInputs = ^{set_en, set_addr, rs1, rs2, src_q};
    assign hz1  = 1'b0;
    assign hz2  = 1'b0;
    assign busy = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter at default geometry. Expected values are
// hand-derived; scoreboard expectations depend on WB_SCOREBOARD_EN.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_arb_pkg::*;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        v0, v1, rdy0, rdy1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        wr_en;
    logic [4:0]  a3;
    logic [31:0] din;
    logic        set_en;
    logic [4:0]  set_addr, rs1, rs2;
    logic        hz1, hz2;
    logic [31:0] busy;

    int testsRun;
    int failCount;

    wb_arbiter #(
        .D_WIDTH       (32),
        .ADDRESS_WIDTH (5),
        .WAIT_MAX      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .v0       (v0),
        .addr0    (addr0),
        .data0    (data0),
        .rdy0     (rdy0),
        .v1       (v1),
        .addr1    (addr1),
        .data1    (data1),
        .rdy1     (rdy1),
        .wr_en    (wr_en),
        .a3       (a3),
        .din      (din),
        .set_en   (set_en),
        .set_addr (set_addr),
        .rs1      (rs1),
        .rs2      (rs2),
        .hz1      (hz1),
        .hz2      (hz2),
        .busy     (busy)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge so registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held two cycles with a port 0 request to x5 that must be dropped.
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            testsRun++;
            if (rdy0 !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL reset_rdy0 cyc %0d: got %b want 1", i, rdy0);
            end
            testsRun++;
            if ({wr_en, a3, din} !== 38'd0) begin
                failCount++;
                $display("[TB] FAIL reset_wstage cyc %0d: got wr_en=%b a3=%0d din=%h want 0/0/0", i, wr_en, a3, din);
            end
            testsRun++;
            if (busy !== 32'd0) begin
                failCount++;
                $display("[TB] FAIL reset_busy cyc %0d: got %h want 0", i, busy);
            end
        end
        rst = 1'b0;
        v0  = 1'b0;
        tick();
        testsRun++;
        if ({wr_en, a3, din} !== 38'd0) begin
            failCount++;
            $display("[TB] FAIL reset_no_x5: got wr_en=%b a3=%0d din=%h want 0/0/0", wr_en, a3, din);
        end
    endtask

    // Both ports request continuously; port 1 wins once every fifth cycle.
    task automatic test_contention();
        logic       expRdy1;
        logic [4:0] expA3;
        v0 = 1'b1; addr0 = 5'd3; data0 = 32'h0000_0030;
        v1 = 1'b1; addr1 = 5'd7; data1 = 32'h0000_0070;
        for (int k = 1; k <= 10; k++) begin
            #1;
            expRdy1 = (k == 5) || (k == 10);
            expA3   = expRdy1 ? 5'd7 : 5'd3;
            testsRun++;
            if ({rdy0, rdy1} !== {~expRdy1, expRdy1}) begin
                failCount++;
                $display("[TB] FAIL contention_grant cyc %0d: got rdy0=%b rdy1=%b want %b/%b", k, rdy0, rdy1, ~expRdy1, expRdy1);
            end
            tick();
            testsRun++;
            if ({wr_en, a3} !== {1'b1, expA3}) begin
                failCount++;
                $display("[TB] FAIL contention_write cyc %0d: got wr_en=%b a3=%0d want 1/%0d", k, wr_en, a3, expA3);
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        tick();
        testsRun++;
        if ({wr_en, a3, din} !== {1'b0, 5'd7, 32'h0000_0070}) begin
            failCount++;
            $display("[TB] FAIL idle_hold: got wr_en=%b a3=%0d din=%h want 0/7/00000070", wr_en, a3, din);
        end
    endtask

    // Port 1 alone is granted at once and written for exactly one cycle.
    task automatic test_single_write();
        v1 = 1'b1; addr1 = 5'd9; data1 = 32'hDEAD_BEEF;
        #1;
        testsRun++;
        if ({rdy0, rdy1} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL single_grant: got rdy0=%b rdy1=%b want 0/1", rdy0, rdy1);
        end
        tick();
        v1 = 1'b0;
        testsRun++;
        if ({wr_en, a3, din} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
            failCount++;
            $display("[TB] FAIL single_write: got wr_en=%b a3=%0d din=%h want 1/9/deadbeef", wr_en, a3, din);
        end
        tick();
        testsRun++;
        if ({wr_en, din} !== {1'b0, 32'hDEAD_BEEF}) begin
            failCount++;
            $display("[TB] FAIL single_one_cycle: got wr_en=%b din=%h want 0/deadbeef", wr_en, din);
        end
    endtask

    // A write to x0 handshakes but never reaches the register file.
    task automatic test_x0();
        v0 = 1'b1; addr0 = 5'd0; data0 = 32'h0000_1234;
        #1;
        testsRun++;
        if (rdy0 !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL x0_grant: got rdy0=%b want 1", rdy0);
        end
        tick();
        v0 = 1'b0;
        testsRun++;
        if (wr_en !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL x0_wr_en: got %b want 0", wr_en);
        end
    endtask

    // Set x12 pending, retire it with a port 1 write, then show that
    // port 0 writes and x0 sets leave the mask alone.
    task automatic test_scoreboard();
        logic [31:0] maskTwelve;
        maskTwelve = 32'h0000_1000;
        set_en = 1'b1; set_addr = 5'd12; rs1 = 5'd12; rs2 = 5'd3;
        #1;
        testsRun++;
        if (hz1 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sb_before_set: got hz1=%b want 0", hz1);
        end
        tick();
        set_en = 1'b0;
        testsRun++;
        if ({hz1, hz2, busy} !== {SB, 1'b0, SB ? maskTwelve : 32'd0}) begin
            failCount++;
            $display("[TB] FAIL sb_after_set: got hz1=%b hz2=%b busy=%h want %b/0/%h", hz1, hz2, busy, SB, SB ? maskTwelve : 32'd0);
        end
        v1 = 1'b1; addr1 = 5'd12; data1 = 32'h0000_C0DE;
        tick();
        v1 = 1'b0;
        testsRun++;
        if ({wr_en, a3, hz1} !== {1'b1, 5'd12, SB}) begin
            failCount++;
            $display("[TB] FAIL sb_write_cycle: got wr_en=%b a3=%0d hz1=%b want 1/12/%b", wr_en, a3, hz1, SB);
        end
        tick();
        testsRun++;
        if ({hz1, busy} !== {1'b0, 32'd0}) begin
            failCount++;
            $display("[TB] FAIL sb_cleared: got hz1=%b busy=%h want 0/0", hz1, busy);
        end
        set_en = 1'b1; set_addr = 5'd12;
        tick();
        set_en = 1'b0;
        v0 = 1'b1; addr0 = 5'd12; data0 = 32'h0000_F00D;
        tick();
        v0 = 1'b0;
        tick();
        testsRun++;
        if (hz1 !== SB) begin
            failCount++;
            $display("[TB] FAIL sb_p0_no_clear: got hz1=%b want %b", hz1, SB);
        end
        set_en = 1'b1; set_addr = 5'd0; rs2 = 5'd0;
        tick();
        set_en = 1'b0;
        testsRun++;
        if ({hz2, busy} !== {1'b0, SB ? maskTwelve : 32'd0}) begin
            failCount++;
            $display("[TB] FAIL sb_x0_set: got hz2=%b busy=%h want 0/%h", hz2, busy, SB ? maskTwelve : 32'd0);
        end
    endtask

    // Port 1 retires x12 in the same cycle a new op marks x12 pending.
    task automatic test_collision();
        logic [31:0] maskTwelve;
        maskTwelve = 32'h0000_1000;
        v1 = 1'b1; addr1 = 5'd12; data1 = 32'h0000_00CC;
        tick();
        v1 = 1'b0;
        set_en = 1'b1; set_addr = 5'd12;
        tick();
        set_en = 1'b0;
        testsRun++;
        if ({hz1, busy} !== {SB, SB ? maskTwelve : 32'd0}) begin
            failCount++;
            $display("[TB] FAIL collision_set_wins: got hz1=%b busy=%h want %b/%h", hz1, busy, SB, SB ? maskTwelve : 32'd0);
        end
    endtask

    // Drive reset with a live request, then run each scenario in turn.
    initial begin
        testsRun  = 0;
        failCount = 0;
        rst = 1'b1;
        v0 = 1'b1; addr0 = 5'd5; data0 = 32'h0000_0055;
        v1 = 1'b0; addr1 = '0; data1 = '0;
        set_en = 1'b0; set_addr = '0; rs1 = '0; rs2 = '0;
        test_reset();
        test_contention();
        test_single_write();
        test_x0();
        test_scoreboard();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
